// File: rtl/ov_7670_pixel_writer.sv
// rtl/ov_7670_pixel_writer.sv - FIFO-buffered pixel writer from OV7670 capture to frame-buffer memory
//
// Purpose:
//   Accepts the addr/data pixel stream from ov_7670_capture, queues it in a
//   small FIFO and drains it to the frame buffer over a req/ack handshake,
//   one write in flight at a time. Flags dropped pixels (overflow) and writes
//   abandoned because the memory never acked (ack_timeout).
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   write_en       pixel valid from capture (one push per high cycle)
//   addr, data_in  pixel address / RGB data, sampled with write_en
//   mem_req        write request to the frame buffer
//   mem_addr       write address, held while waiting for ack
//   mem_wdata      write data, held while waiting for ack
//   mem_ack        memory accepted the current write
//   clear_err      synchronous clear of overflow / ack_timeout
//   fifo_count     entries held, including the one in flight
//   overflow       sticky: a pixel was dropped on a full FIFO
//   ack_timeout    sticky: a write was abandoned after TIMEOUT cycles
//   pixels_written count of acked writes, wraps modulo 2^ADDR_W

module ov_7670_pixel_writer #(
  parameter int DEPTH   = 16,
  parameter int ADDR_W  = 19,
  parameter int DATA_W  = 24,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       write_en,
  input  logic [ADDR_W-1:0]          addr,
  input  logic [DATA_W-1:0]          data_in,
  output logic                       mem_req,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic                       clear_err,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       overflow,
  output logic                       ack_timeout,
  output logic [ADDR_W-1:0]          pixels_written
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam int ENT_W = ADDR_W + DATA_W;

  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  // Pixel storage: contents need no reset, only the pointers do.
  logic [ENT_W-1:0] fifo_mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              overflow_q, overflow_d;
  logic              ack_timeout_q, ack_timeout_d;
  logic [ADDR_W-1:0] pixels_written_q, pixels_written_d;

  logic              in_req;
  logic              do_ack;
  logic              do_drop;
  logic              do_pop;
  logic              do_push;
  logic [PTR_W-1:0]  rd_next;
  logic [ENT_W-1:0]  push_ent;
  logic [ENT_W-1:0]  head_ent;
  logic [ENT_W-1:0]  next_ent;

  always_comb begin
    in_req   = (state_q == ST_REQ);
    do_ack   = in_req && mem_ack;
    // Timeout counter reaches TIMEOUT on this edge: abandon the entry.
    do_drop  = in_req && !mem_ack && (tmo_q == TMO_LAST);
    do_pop   = do_ack || do_drop;
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    do_push  = write_en && ((count_q != DEPTH_C) || do_pop);
    rd_next  = rd_ptr_q + PTR_W'(1);
    push_ent = {addr, data_in};
    head_ent = fifo_mem[rd_ptr_q];
    // With only the in-flight entry stored, the follow-on entry can only be
    // the pixel arriving this cycle, which is not yet in the memory.
    next_ent = (count_q == CNT_ONE) ? push_ent : fifo_mem[rd_next];
  end

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    count_d          = count_q;
    tmo_d            = tmo_q;
    mem_req_d        = mem_req_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    overflow_d       = overflow_q;
    ack_timeout_d    = ack_timeout_q;
    pixels_written_d = pixels_written_q;

    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_next;
    end

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      ST_IDLE: begin
        mem_req_d = 1'b0;
        if (count_q != '0) begin
          mem_addr_d  = head_ent[ENT_W-1:DATA_W];
          mem_wdata_d = head_ent[DATA_W-1:0];
          mem_req_d   = 1'b1;
          tmo_d       = '0;
          state_d     = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          pixels_written_d = pixels_written_q + ADDR_W'(1);
          // Chain straight into the next entry for one write per cycle.
          if ((count_q > CNT_ONE) || do_push) begin
            mem_addr_d  = next_ent[ENT_W-1:DATA_W];
            mem_wdata_d = next_ent[DATA_W-1:0];
            mem_req_d   = 1'b1;
            tmo_d       = '0;
          end else begin
            mem_req_d = 1'b0;
            state_d   = ST_IDLE;
          end
        end else if (do_drop) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Set events take priority over clear_err.
    if (write_en && !do_push) begin
      overflow_d = 1'b1;
    end else if (clear_err) begin
      overflow_d = 1'b0;
    end

    if (do_drop) begin
      ack_timeout_d = 1'b1;
    end else if (clear_err) begin
      ack_timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      fifo_mem[wr_ptr_q] <= push_ent;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      count_q          <= '0;
      tmo_q            <= '0;
      mem_req_q        <= 1'b0;
      mem_addr_q       <= '0;
      mem_wdata_q      <= '0;
      overflow_q       <= 1'b0;
      ack_timeout_q    <= 1'b0;
      pixels_written_q <= '0;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      count_q          <= count_d;
      tmo_q            <= tmo_d;
      mem_req_q        <= mem_req_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      overflow_q       <= overflow_d;
      ack_timeout_q    <= ack_timeout_d;
      pixels_written_q <= pixels_written_d;
    end
  end

  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign fifo_count     = count_q;
  assign overflow       = overflow_q;
  assign ack_timeout    = ack_timeout_q;
  assign pixels_written = pixels_written_q;

endmodule

// File: doc/ov_7670_pixel_writer.md
Name: ov_7670_pixel_writer

Overview:
- Sits directly downstream of ov_7670_capture; consumes its addr / data_out / write_en pixel stream.
- Buffers pixels in a small FIFO and writes them to the frame-buffer memory over a req/ack handshake.
- Flags overflow and a stuck memory port (ack timeout).
- Single clock domain (system clock); one pixel write in flight at a time.

Parameters:
- DEPTH, 16, FIFO entries (power of two, 4..64).
- ADDR_W, 19, pixel address width (640x480 frame).
- DATA_W, 24, pixel data width (RGB888).
- TIMEOUT, 255, clk cycles mem_req may wait for mem_ack before the entry is dropped (>=2).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- write_en  input  1  pixel valid from capture; one push per cycle high.
- addr  input  ADDR_W  pixel address, sampled with write_en.
- data_in  input  DATA_W  pixel data, sampled with write_en.
- mem_req  output  1  write request to frame buffer.
- mem_addr  output  ADDR_W  write address, stable while mem_req=1 and no ack.
- mem_wdata  output  DATA_W  write data, stable while mem_req=1 and no ack.
- mem_ack  input  1  memory accepted the current write (sampled at clk edge while mem_req=1).
- clear_err  input  1  synchronous clear of sticky error flags.
- fifo_count  output  $clog2(DEPTH)+1  entries held, including the in-flight one.
- overflow  output  1  sticky: a pixel was dropped because the FIFO was full.
- ack_timeout  output  1  sticky: a write was abandoned after TIMEOUT cycles.
- pixels_written  output  ADDR_W  count of acked writes; wraps modulo 2^ADDR_W.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count go to 0; contents are discarded.
  - State goes to IDLE.
  - All outputs go to 0; mem_req falls immediately, even mid-handshake.
- Push rules:
  - When write_en=1 and (count<DEPTH, or a pop occurs in the same cycle), {addr,data_in} is stored at the tail.
  - Otherwise, when write_en=1, the pixel is dropped and overflow is set to 1.
  - Push and pop in the same cycle leave count unchanged, including when full.
- Entries are removed only by a pop: an ack, or a timeout drop. An entry remains counted while it is in flight.
- State machine, 2 states, fully registered outputs:
  - IDLE:
    - mem_req=0.
    - If count!=0, latch the head entry into mem_addr/mem_wdata, set mem_req=1, clear the timeout counter and go to REQ.
    - A pixel pushed into an empty FIFO therefore appears on mem_req 2 cycles after its write_en cycle.
  - REQ, mem_ack=1:
    - Pop; pixels_written increments.
    - If count_after (count - 1 + accepted push) >= 1, latch the next entry into mem_addr/mem_wdata on the same edge, keep mem_req=1, clear the timeout counter and stay in REQ. Sustained rate is one write per cycle.
    - Otherwise, mem_req=0 and go to IDLE.
  - REQ, mem_ack=0:
    - The timeout counter increments.
    - When it reaches TIMEOUT, pop the entry without a write (pixels_written unchanged), set ack_timeout, set mem_req=0 and go to IDLE.
    - The next request may start the following cycle.
- mem_ack while mem_req=0 is ignored.
- mem_addr/mem_wdata hold their last value while idle.
- clear_err=1 clears overflow and ack_timeout next edge. If a set event occurs in the same cycle, set wins.
- fifo_count is registered and reflects pushes/pops of the previous edge.
- pixels_written is ADDR_W wide and wraps from 2^ADDR_W-1 to 0 with no flag.

Test Plan:
- Single pixel: reset, write_en one cycle with addr=0x00010, data=0xABCDEF, mem_ack tied 1 -> mem_req high exactly cycle+2 with addr 0x00010/data 0xABCDEF for 1 cycle; pixels_written=1; fifo_count back to 0.
- Burst, back-to-back: 8 consecutive pushes addr 0..7, mem_ack=1 -> 8 consecutive mem_req cycles, addresses 0..7 in order, no gaps, overflow=0.
- Overflow: mem_ack=0 (TIMEOUT large, e.g. 1000), push 20 pixels -> fifo_count saturates at 16, overflow=1. Then ack continuously -> exactly 16 writes, addresses of the first 16 pushes. clear_err -> overflow=0.
- Full plus simultaneous push/pop: FIFO full, push on an ack cycle -> accepted, fifo_count stays 16, overflow stays 0.
- Timeout: TIMEOUT=4, push 2 pixels, mem_ack=0 -> first request held 4 cycles, then dropped with ack_timeout=1 and mem_req low 1 cycle. Second pixel is then requested; pixels_written=0 until an ack arrives.
- Async reset mid-write: assert reset while mem_req=1 with 5 entries queued -> mem_req=0 immediately, fifo_count=0. After release, no stale write is issued.
